modinv_verify: RTL and testbench
================================

MODINV_VERIFY -- requirements
Module: modinv_verify

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port e  input  WIDTH  public exponent.
REQ-006 SHALL have port d  input  WIDTH  candidate private exponent (modular inverse under test).
REQ-007 SHALL have port phi  input  WIDTH  modulus (Euler totient).
REQ-008 SHALL have port product  output  WIDTH  (e*d) mod phi; held until the next accepted start.
REQ-009 SHALL have port ok  output  1  product==1 and no error; held like product.
REQ-010 SHALL have port err  output  1  operand range error; held like product.
REQ-011 SHALL have port valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, MUL, DONE.
REQ-014 IDLE: start=1 SHALL latch e, d and phi into internal registers, clear product/ok/err, and go to LOAD; start=0 SHALL stay in IDLE.
REQ-015 start asserted outside IDLE SHALL be ignored with no effect on latched operands.
REQ-016 Input changes after the start cycle SHALL NOT affect the result.
REQ-017 LOAD: if phi<2, e>=phi, or d>=phi, the block SHALL set err=1, product=0 and go to DONE.
REQ-018 LOAD, otherwise: the block SHALL clear accumulator P, set bit index to WIDTH-1 and go to MUL.
REQ-019 MUL: each cycle SHALL process one bit of e, MSB first, as follows: P1 = 2P, minus phi if 2P >= phi; P2 = P1 + d if e[idx]=1, else P1; P2 minus phi if P2 >= phi.
REQ-020 Internal sums SHALL be WIDTH+1 bits wide so that 2P and P1+d never overflow; P SHALL stay < phi at all times.
REQ-021 MUL SHALL run exactly WIDTH cycles; after idx==0 it SHALL go to DONE; idx SHALL not wrap.
REQ-022 DONE: the block SHALL drive product=P, ok=(P==1 && !err), pulse valid=1 for exactly one cycle, then return to IDLE.
REQ-023 Latency: with start accepted at cycle 0, valid SHALL be high at cycle WIDTH+2 (258 for the default); on the error path it SHALL be high at cycle 2.
REQ-024 busy SHALL be 1 from the cycle after start acceptance through the DONE cycle.
REQ-025 A start in the cycle after DONE (back in IDLE) SHALL be accepted normally.
REQ-026 d=0 or e=0 with phi>=2 SHALL produce product=0, ok=0, err=0.

Reset
REQ-027 rst=1 SHALL force IDLE and clear product, ok, err, valid, busy, P and idx to 0 on the next edge, with priority over start and over any in-flight operation.
REQ-028 An operation interrupted by reset SHALL produce no valid pulse.

Verification
REQ-029 Bench SHALL cover: e=3, d=7, phi=20 -> valid at cycle 258, product=1, ok=1, err=0.
REQ-030 Bench SHALL cover: e=17, d=2753, phi=3120 -> product=1, ok=1; then e=3, d=6, phi=20 -> product=18, ok=0.
REQ-031 Bench SHALL cover: e=25, d=7, phi=20 -> valid at cycle 2, err=1, ok=0, product=0; phi=1 -> err=1.
REQ-032 Bench SHALL cover: start re-pulsed and inputs changed during MUL -> result equals that of the original operands, exactly one valid pulse.
REQ-033 Bench SHALL cover: rst at cycle 100 of an operation -> all outputs 0 and no valid pulse; a subsequent start with e=3, d=7, phi=20 completes with ok=1.
REQ-034 Bench SHALL cover: 1000 random operand sets with phi>=2, e<phi, d<phi -> product matches reference model (e*d) mod phi.

Source files
------------

// File: rtl/modinv_verify.sv
// Modular-inverse checker: computes (e*d) mod phi by MSB-first
// shift-and-add with per-step reduction, flags ok when the product is 1.
module modinv_verify #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] phi,
  output logic [WIDTH-1:0] product,
  output logic             ok,
  output logic             err,
  output logic             valid,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MUL,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] phi_q;
  logic [WIDTH-1:0] p_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] product_q;
  logic             ok_q;
  logic             err_q;
  logic             valid_q;
  logic             busy_q;

  logic [WIDTH:0]   phi_x;
  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] p_d;
  logic             range_err;

  // One multiply step: double, reduce, conditionally add d, reduce.
  // Sums are one bit wider so 2P and P1+d cannot overflow.
  always_comb begin
    phi_x     = {1'b0, phi_q};
    dbl       = {p_q, 1'b0};
    p1        = (dbl >= phi_x) ? WIDTH'(dbl - phi_x) : WIDTH'(dbl);
    addend    = e_q[idx_q] ? d_q : '0;
    sum       = {1'b0, p1} + {1'b0, addend};
    p_d       = (sum >= phi_x) ? WIDTH'(sum - phi_x) : WIDTH'(sum);
    range_err = (phi_q < WIDTH'(2)) || (e_q >= phi_q) || (d_q >= phi_q);
  end

  // Control FSM with registered outputs; valid is raised on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      e_q       <= '0;
      d_q       <= '0;
      phi_q     <= '0;
      p_q       <= '0;
      idx_q     <= '0;
      product_q <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            e_q       <= e;
            d_q       <= d;
            phi_q     <= phi;
            product_q <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (range_err) begin
            err_q     <= 1'b1;
            ok_q      <= 1'b0;
            product_q <= '0;
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            p_q     <= '0;
            idx_q   <= IW'(WIDTH - 1);
            state_q <= MUL;
          end
        end
        MUL: begin
          p_q <= p_d;
          if (idx_q == '0) begin
            product_q <= p_d;
            ok_q      <= (p_d == WIDTH'(1));
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign product = product_q;
  assign ok      = ok_q;
  assign err     = err_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_modinv_verify.sv
// Bench for modinv_verify: directed table and corner sequences on the
// 256-bit instance, random operands against (e*d) mod phi on both widths.
module tb_modinv_verify;

  localparam int W  = 256;
  localparam int WS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          sa;
  logic [W-1:0]  ea, da, pa, proda;
  logic          oka, erra, va, ba;

  logic          sb;
  logic [WS-1:0] eb, db, pb, prodb;
  logic          okb, errb, vb, bb;

  modinv_verify #(.WIDTH(W)) dut_a (
    .clk(clk), .rst(rst), .start(sa),
    .e(ea), .d(da), .phi(pa),
    .product(proda), .ok(oka), .err(erra),
    .valid(va), .busy(ba)
  );

  modinv_verify #(.WIDTH(WS)) dut_b (
    .clk(clk), .rst(rst), .start(sb),
    .e(eb), .d(db), .phi(pb),
    .product(prodb), .ok(okb), .err(errb),
    .valid(vb), .busy(bb)
  );

  int errors = 0;
  int checks = 0;
  int vcnt_a = 0;

  always @(negedge clk) if (va === 1'b1) vcnt_a++;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_vec_a(input string tag,
                          input logic [W-1:0] e_, d_, p_, xp,
                          input logic xok, xerr, input int xcyc);
    int cyc;
    ea = e_; da = d_; pa = p_; sa = 1'b1;
    @(posedge clk); #1;
    sa = 1'b0;
    chk({tag, "_busy"}, W'(ba), W'(1));
    cyc = 1;
    while (va !== 1'b1 && cyc < W + 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_cycle"}, W'(cyc), W'(xcyc));
    chk({tag, "_product"}, proda, xp);
    chk({tag, "_ok"}, W'(oka), W'(xok));
    chk({tag, "_err"}, W'(erra), W'(xerr));
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, W'(va), W'(0));
    chk({tag, "_busy_drop"}, W'(ba), W'(0));
    chk({tag, "_hold"}, proda, xp);
  endtask

  task automatic do_vec_b(input logic [WS-1:0] e_, d_, p_, xp);
    int cyc;
    eb = e_; db = d_; pb = p_; sb = 1'b1;
    @(posedge clk); #1;
    sb = 1'b0;
    cyc = 1;
    while (vb !== 1'b1 && cyc < WS + 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rnd16_cycle", W'(cyc), W'(WS + 2));
    chk("rnd16_product", W'(prodb), W'(xp));
    chk("rnd16_ok", W'(okb), W'(xp == WS'(1)));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0] e, d, phi, prod;
    logic         ok, err;
    int           cyc;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [W-1:0]   re, rd, rp;
    logic [2*W-1:0] m;
    logic [WS-1:0]  se, sd, sp;
    longint unsigned sm;
    int             v0, cyc;

    tbl[0]  = '{W'(3),  W'(7),    W'(20),   W'(1),  1'b1, 1'b0, W + 2};
    tbl[1]  = '{W'(17), W'(2753), W'(3120), W'(1),  1'b1, 1'b0, W + 2};
    tbl[2]  = '{W'(3),  W'(6),    W'(20),   W'(18), 1'b0, 1'b0, W + 2};
    tbl[3]  = '{W'(25), W'(7),    W'(20),   W'(0),  1'b0, 1'b1, 2};
    tbl[4]  = '{W'(0),  W'(0),    W'(1),    W'(0),  1'b0, 1'b1, 2};
    tbl[5]  = '{W'(0),  W'(5),    W'(20),   W'(0),  1'b0, 1'b0, W + 2};
    tbl[6]  = '{W'(5),  W'(0),    W'(20),   W'(0),  1'b0, 1'b0, W + 2};
    tbl[7]  = '{W'(3),  W'(20),   W'(20),   W'(0),  1'b0, 1'b1, 2};
    tbl[8]  = '{W'(0),  W'(0),    W'(0),    W'(0),  1'b0, 1'b1, 2};
    tbl[9]  = '{W'(0),  W'(0),    '1,       W'(1),  1'b1, 1'b0, W + 2};
    tbl[9].e = tbl[9].phi - 1'b1;
    tbl[9].d = tbl[9].phi - 1'b1;
    tbl[10] = '{W'(1),  W'(1),    W'(2),    W'(1),  1'b1, 1'b0, W + 2};

    rst = 1'b1;
    sa = 1'b0; ea = '0; da = '0; pa = '0;
    sb = 1'b0; eb = '0; db = '0; pb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_product", proda, '0);
    chk("rst_flags", W'({oka, erra, va, ba}), W'(0));

    for (int i = 0; i < 11; i++)
      do_vec_a($sformatf("tbl%0d", i), tbl[i].e, tbl[i].d, tbl[i].phi,
               tbl[i].prod, tbl[i].ok, tbl[i].err, tbl[i].cyc);

    // start re-pulsed and operands changed mid-operation
    v0 = vcnt_a;
    ea = W'(3); da = W'(7); pa = W'(20); sa = 1'b1;
    @(posedge clk); #1;
    sa = 1'b0;
    cyc = 1;
    repeat (10) begin @(posedge clk); #1; cyc++; end
    ea = W'(25); da = W'(9); pa = W'(31); sa = 1'b1;
    repeat (5) begin @(posedge clk); #1; cyc++; end
    sa = 1'b0;
    while (va !== 1'b1 && cyc < W + 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("restart_cycle", W'(cyc), W'(W + 2));
    chk("restart_product", proda, W'(1));
    chk("restart_ok", W'(oka), W'(1));
    repeat (300) @(posedge clk);
    #1;
    chk("restart_pulses", W'(vcnt_a - v0), W'(1));

    // reset in cycle 100 of an operation
    ea = W'(3); da = W'(7); pa = W'(20); sa = 1'b1;
    @(posedge clk); #1;
    sa = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    v0 = vcnt_a;
    chk("abort_product", proda, '0);
    chk("abort_flags", W'({oka, erra, va, ba}), W'(0));
    repeat (300) @(posedge clk);
    #1;
    chk("abort_no_valid", W'(vcnt_a - v0), W'(0));
    do_vec_a("after_abort", W'(3), W'(7), W'(20), W'(1), 1'b1, 1'b0, W + 2);

    // wide random operands
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < W / 32; k++) rp[k*32 +: 32] = $urandom;
      rp = rp >> $urandom_range(200, 0);
      if (rp < W'(2)) rp = W'(2);
      for (int k = 0; k < W / 32; k++) re[k*32 +: 32] = $urandom;
      for (int k = 0; k < W / 32; k++) rd[k*32 +: 32] = $urandom;
      re = re % rp;
      rd = rd % rp;
      m = ({{W{1'b0}}, re} * {{W{1'b0}}, rd}) % {{W{1'b0}}, rp};
      do_vec_a("rnd256", re, rd, rp, m[W-1:0], m == 1, 1'b0, W + 2);
    end

    // narrow random operands
    for (int n = 0; n < 1000; n++) begin
      sp = WS'($urandom_range(65535, 2));
      se = WS'($urandom % sp);
      sd = WS'($urandom % sp);
      sm = (longint'(se) * longint'(sd)) % longint'(sp);
      do_vec_b(se, sd, sp, WS'(sm));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
